// File: rtl/bird_hit_manager.sv
// bird_hit_manager: per-bird alive/exploding/dead life cycle, timed respawn and saturating score
module bird_hit_manager #(
    parameter int NUM_OF_BIRDS    = 4,
    parameter int EXPLODE_FRAMES  = 16,
    parameter int RESPAWN_FRAMES  = 120,
    parameter int POINTS_PER_BIRD = 10,
    parameter int SCORE_MAX       = 9999
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic [NUM_OF_BIRDS-1:0] SingleHitPulse_birds,
    output logic [NUM_OF_BIRDS-1:0] birdsActive,
    output logic [NUM_OF_BIRDS-1:0] birdsExploding,
    output logic [NUM_OF_BIRDS-1:0] respawnPulse,
    output logic [13:0]             score,
    output logic                    waveCleared
);
    typedef enum logic [1:0] {ALIVE, EXPLODING, DEAD} bird_state_t;

    bird_state_t             state      [NUM_OF_BIRDS];
    bird_state_t             state_next [NUM_OF_BIRDS];
    logic [7:0]              cnt        [NUM_OF_BIRDS];
    logic [7:0]              cnt_next   [NUM_OF_BIRDS];
    logic [NUM_OF_BIRDS-1:0] prev, hit_edge, kill, respawn_next, alive_next, exploding_next;
    logic                    sof_prev, tick, wave_next;
    logic [3:0]              kills;
    logic [17:0]             sum;
    logic [13:0]             score_next;

    assign hit_edge = SingleHitPulse_birds & ~prev;
    assign tick     = startOfFrame & ~sof_prev;

    // Per-bird next state and frame counter; a bird already dying ignores hits, so a respawn beats a same-cycle hit
    always_comb begin
        kill           = '0;
        respawn_next   = '0;
        alive_next     = '0;
        exploding_next = '0;
        for (int i = 0; i < NUM_OF_BIRDS; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                ALIVE: if (hit_edge[i]) begin
                    state_next[i] = EXPLODING;
                    cnt_next[i]   = 8'(EXPLODE_FRAMES);
                    kill[i]       = 1'b1;
                end
                EXPLODING: if (tick) begin
                    if (cnt[i] == 8'd1) begin
                        state_next[i] = DEAD;
                        cnt_next[i]   = 8'(RESPAWN_FRAMES);
                    end else begin
                        cnt_next[i] = cnt[i] - 8'd1;
                    end
                end
                DEAD: if (tick) begin
                    if (cnt[i] == 8'd1) begin
                        state_next[i]   = ALIVE;
                        cnt_next[i]     = 8'd0;
                        respawn_next[i] = 1'b1;
                    end else begin
                        cnt_next[i] = cnt[i] - 8'd1;
                    end
                end
                default: state_next[i] = ALIVE;
            endcase
            alive_next[i]     = state_next[i] == ALIVE;
            exploding_next[i] = state_next[i] == EXPLODING;
        end
    end

    // Kill count, widened score sum with clamp, and wave-cleared detection
    always_comb begin
        kills = '0;
        for (int i = 0; i < NUM_OF_BIRDS; i++) kills = kills + 4'(kill[i]);
        sum        = 18'(score) + 18'(kills) * 18'(POINTS_PER_BIRD);
        score_next = (sum > 18'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum[13:0];
        wave_next  = (|kill) && !(|alive_next);
    end

    // State, counters, edge history and all outputs are registered here
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OF_BIRDS; i++) begin
                state[i] <= ALIVE;
                cnt[i]   <= 8'd0;
            end
            prev           <= '0;
            sof_prev       <= 1'b0;
            birdsActive    <= '1;
            birdsExploding <= '0;
            respawnPulse   <= '0;
            score          <= '0;
            waveCleared    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OF_BIRDS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            prev           <= SingleHitPulse_birds;
            sof_prev       <= startOfFrame;
            birdsActive    <= alive_next;
            birdsExploding <= exploding_next;
            respawnPulse   <= respawn_next;
            score          <= score_next;
            waveCleared    <= wave_next;
        end
    end
endmodule

// File: tb/tb_bird_hit_manager.sv
// tb_bird_hit_manager: scoreboard bench; expected output changes are queued with their due time
module tb_bird_hit_manager;
    logic        clk = 1'b0, resetN = 1'b1, sof = 1'b0, rst2_n = 1'b1, sof2 = 1'b0;
    logic [3:0]  hits = '0, hits2 = '0;
    logic [3:0]  act, expl, resp, act2, expl2, resp2;
    logic [13:0] score, score2;
    logic        wc, wc2;
    int          tests = 0, fails = 0;

    typedef struct {
        string       name;
        logic [26:0] v;
        time         due;
    } exp_t;

    exp_t        q[$];
    logic [13:0] q2[$];
    logic [3:0]  e_act = 4'hf, e_exp = '0, e_resp = '0;
    logic [13:0] e_sc = '0;
    logic        e_wc = 1'b0;
    logic [26:0] last = 'x;
    localparam logic [26:0] RST_SNAP = {4'hf, 4'h0, 4'h0, 14'd0, 1'b0};

    always #5 clk = ~clk;

    bird_hit_manager dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .SingleHitPulse_birds(hits),
        .birdsActive(act), .birdsExploding(expl), .respawnPulse(resp), .score(score), .waveCleared(wc)
    );

    bird_hit_manager #(.EXPLODE_FRAMES(1), .RESPAWN_FRAMES(1), .POINTS_PER_BIRD(5), .SCORE_MAX(9999)) dut2 (
        .clk(clk), .resetN(rst2_n), .startOfFrame(sof2), .SingleHitPulse_birds(hits2),
        .birdsActive(act2), .birdsExploding(expl2), .respawnPulse(resp2), .score(score2), .waveCleared(wc2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // queue the current expected outputs, due d negedges from now (only when they change)
    task automatic push(input string name, input int d);
        logic [26:0] s;
        s = {e_act, e_exp, e_resp, e_sc, e_wc};
        if (s !== last) begin
            q.push_back('{name, s, (($time / 10) + d) * 10});
            last = s;
        end
    endtask

    task automatic monitor();
        logic [26:0] cur, prev_s;
        logic [13:0] prev2;
        exp_t        e;
        prev_s = 'x;
        prev2  = '0;
        forever begin
            @(negedge clk);
            cur = {act, expl, resp, score, wc};
            while (q.size() > 0 && q[0].due < $time) begin
                e = q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: output still 0x%0h at t=%0t, expected 0x%0h by t=%0t", e.name, cur, $time, e.v, e.due);
            end
            if (cur !== prev_s) begin
                if (q.size() > 0 && q[0].due == $time) begin
                    e = q.pop_front();
                    check(e.name, 32'(cur), 32'(e.v));
                end else begin
                    check("unexpected_change", 32'(cur), 32'(prev_s));
                end
                prev_s = cur;
            end
            if (score2 !== prev2) begin
                if (q2.size() > 0) check("sat_score", 32'(score2), 32'(q2.pop_front()));
                else check("sat_unexpected", 32'(score2), 32'(prev2));
                prev2 = score2;
            end
        end
    endtask

    task automatic tick();
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        e_act = 4'hf; e_exp = '0; e_resp = '0; e_sc = '0; e_wc = 1'b0;
        push("reset", 1);
        #2 resetN = 1'b0;
        #1 check("reset_async", 32'({act, expl, resp, score, wc}), 32'(RST_SNAP));
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic sat_round(input logic [3:0] h);
        hits2 = h;
        @(negedge clk);
        hits2 = '0; sof2 = 1'b1;
        @(negedge clk);
        sof2 = 1'b0;
        @(negedge clk);
        sof2 = 1'b1;
        @(negedge clk);
        sof2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        fork monitor(); join_none
        #1;
        push("reset_init", 1);
        resetN = 1'b0; rst2_n = 1'b0;
        @(negedge clk);
        resetN = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        // hit held high for 100 cycles counts once
        hits = 4'b0001;
        e_act = 4'b1110; e_exp = 4'b0001; e_sc = 14'd10;
        push("hit0_held", 1);
        repeat (100) @(negedge clk);
        hits = '0;
        @(negedge clk);
        do_reset();
        // bird 2 full life cycle; respawn tick coincides with a hit, which is dropped
        hits = 4'b0100;
        e_act = 4'b1011; e_exp = 4'b0100; e_sc = 14'd10;
        push("hit2", 1);
        @(negedge clk);
        hits = '0;
        for (int k = 1; k <= 136; k++) begin
            if (k == 16) begin
                e_exp = '0;
                push("explode_end", 1);
            end
            if (k == 136) begin
                hits = 4'b0100;
                e_act = 4'hf; e_resp = 4'b0100;
                push("respawn", 1);
                e_resp = '0;
                push("respawn_end", 2);
            end
            tick();
        end
        hits = '0;
        @(negedge clk);
        hits = 4'b0100;
        e_act = 4'b1011; e_exp = 4'b0100; e_sc = 14'd20;
        push("rehit2", 1);
        @(negedge clk);
        hits = '0;
        @(negedge clk);
        do_reset();
        // three simultaneous kills, then the last bird clears the wave
        hits = 4'b1011;
        e_act = 4'b0100; e_exp = 4'b1011; e_sc = 14'd30;
        push("triple", 1);
        @(negedge clk);
        hits = '0;
        @(negedge clk);
        hits = 4'b0100;
        e_act = 4'b0000; e_exp = 4'hf; e_sc = 14'd40; e_wc = 1'b1;
        push("wave", 1);
        e_wc = 1'b0;
        push("wave_end", 2);
        @(negedge clk);
        hits = '0;
        @(negedge clk);
        // hits on exploding and then dead birds change nothing
        for (int f = 1; f <= 21; f++) begin
            hits = 4'hf;
            if (f == 16) begin
                e_exp = '0;
                push("all_dead", 1);
            end
            tick();
            hits = '0;
            @(negedge clk);
        end
        do_reset();
        // reset mid-explosion, then hit together with a frame tick
        hits = 4'b0001;
        e_act = 4'b1110; e_exp = 4'b0001; e_sc = 14'd10;
        push("hit0", 1);
        @(negedge clk);
        hits = '0;
        repeat (9) tick();
        do_reset();
        hits = 4'b0001; sof = 1'b1;
        e_act = 4'b1110; e_exp = 4'b0001; e_sc = 14'd10;
        push("hit0_sof", 1);
        @(negedge clk);
        hits = '0; sof = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) begin
                e_exp = '0;
                push("explode_full", 1);
            end
            tick();
        end
        // saturation on the second instance
        for (int r = 1; r <= 500; r++) begin
            q2.push_back(r < 500 ? 14'(20 * r) : 14'd9995);
            sat_round(r < 500 ? 4'hf : 4'b0111);
        end
        q2.push_back(14'd9999);
        sat_round(4'b0001);
        sat_round(4'hf);
        sat_round(4'b0010);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size() + q2.size()), 32'd0);
        check("sat_final", 32'(score2), 32'd9999);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
